// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the SRAM burst port controller.
// Holds the FSM state encoding and the default BITS/WORDS/ADRESS_WIDTH values.
package sram_ctrl_pkg;

   localparam int DEF_BITS         = 32;
   localparam int DEF_WORDS        = 36;
   localparam int DEF_ADRESS_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_BURST = 2'd2
   } state_t;

endpackage

// File: rtl/sram_port_ctrl_if.sv
// Host-side burst interface: request, write-data and read-data handshakes.
// master = host issuing bursts, slave = sram_port_ctrl.
interface sram_port_ctrl_if #(
   parameter int BITS         = 32,
   parameter int ADRESS_WIDTH = 6
);

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADRESS_WIDTH-1:0] req_adress;
   logic [2:0]              req_len;
   logic [BITS-1:0]         req_mask;

   logic                    wdata_valid;
   logic                    wdata_ready;
   logic [BITS-1:0]         wdata;

   logic                    rdata_valid;
   logic                    rdata_ready;
   logic [BITS-1:0]         rdata;
   logic                    rdata_last;
   logic                    rdata_err;

   modport master (
      output req_valid, req_write, req_adress, req_len, req_mask,
      output wdata_valid, wdata, rdata_ready,
      input  req_ready, wdata_ready,
      input  rdata_valid, rdata, rdata_last, rdata_err
   );

   modport slave (
      input  req_valid, req_write, req_adress, req_len, req_mask,
      input  wdata_valid, wdata, rdata_ready,
      output req_ready, wdata_ready,
      output rdata_valid, rdata, rdata_last, rdata_err
   );

endinterface

// File: rtl/sram_addr_gen.sv
// Burst address generator: load start address, step per beat, wrap at WORDS.
// Ports: load/load_addr (burst start), inc (beat issued), addr, oor (addr >= WORDS).
module sram_addr_gen
   import sram_ctrl_pkg::*;
#(
   parameter int WORDS        = DEF_WORDS,
   parameter int ADRESS_WIDTH = DEF_ADRESS_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [ADRESS_WIDTH-1:0] load_addr,
   input  logic                    inc,
   output logic [ADRESS_WIDTH-1:0] addr,
   output logic                    oor
);

   localparam int WIDE = ADRESS_WIDTH + 1;

   logic at_top;

   assign at_top = (addr == ADRESS_WIDTH'(WORDS - 1));

   // One extra bit so WORDS == 2**ADRESS_WIDTH does not alias to zero.
   assign oor = ({1'b0, addr} >= WIDE'(WORDS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_addr;
      end else if (inc) begin
         addr <= at_top ? '0 : addr + 1'b1;
      end
   end

endmodule

// File: rtl/sram_port_ctrl.sv
// Burst controller between a valid/ready host port and a single-port SRAM.
// Ports: clk, rst_n, bus (slave modport), busy, sram_cen/wen/adress/din/mask, sram_dout.
module sram_port_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int BITS         = DEF_BITS,
   parameter int WORDS        = DEF_WORDS,
   parameter int ADRESS_WIDTH = DEF_ADRESS_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sram_port_ctrl_if.slave         bus,
   output logic                    busy,
   output logic                    sram_cen,
   output logic                    sram_wen,
   output logic [ADRESS_WIDTH-1:0] sram_adress,
   output logic [BITS-1:0]         sram_din,
   output logic [BITS-1:0]         sram_mask,
   input  logic [BITS-1:0]         sram_dout
);

   state_t                  state;
   logic [2:0]              len;
   logic [2:0]              cnt;
   logic [BITS-1:0]         mask;

   logic                    rd_valid;
   logic [BITS-1:0]         rd_data;
   logic                    rd_last;
   logic                    rd_err;

   logic [ADRESS_WIDTH-1:0] addr;
   logic                    oor;

   logic                    accept;
   logic                    wr_beat;
   logic                    rd_beat;
   logic                    beat;
   logic                    last_beat;

   assign accept    = bus.req_valid && (state == IDLE);
   assign wr_beat   = (state == WR_BURST) && bus.wdata_valid;
   // A read beat only issues when the output register is free or draining.
   assign rd_beat   = (state == RD_BURST) &&
                      (!rd_valid || bus.rdata_ready);
   assign beat      = wr_beat || rd_beat;
   assign last_beat = (cnt == len);

   sram_addr_gen #(
      .WORDS        (WORDS),
      .ADRESS_WIDTH (ADRESS_WIDTH)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .load_addr (bus.req_adress),
      .inc       (beat),
      .addr      (addr),
      .oor       (oor)
   );

   assign bus.req_ready   = (state == IDLE);
   assign bus.wdata_ready = (state == WR_BURST);
   assign bus.rdata_valid = rd_valid;
   assign bus.rdata       = rd_data;
   assign bus.rdata_last  = rd_last;
   assign bus.rdata_err   = rd_err;

   assign busy = (state != IDLE) || rd_valid;

   // Out-of-range beats still consume a slot but never reach the SRAM.
   assign sram_cen    = beat && !oor;
   assign sram_wen    = wr_beat && !oor;
   assign sram_adress = beat ? addr : '0;
   assign sram_din    = wr_beat ? bus.wdata : '0;
   assign sram_mask   = wr_beat ? mask : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         len      <= '0;
         cnt      <= '0;
         mask     <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_last  <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  len   <= bus.req_len;
                  mask  <= bus.req_mask;
                  cnt   <= '0;
                  state <= bus.req_write ? WR_BURST : RD_BURST;
               end
            end
            WR_BURST, RD_BURST: begin
               if (beat) begin
                  if (last_beat) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + 3'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (rd_beat) begin
            rd_valid <= 1'b1;
            rd_data  <= oor ? '0 : sram_dout;
            rd_err   <= oor;
            rd_last  <= last_beat;
         end else if (bus.rdata_ready) begin
            rd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed testbench for sram_port_ctrl with a behavioural SRAM model.
// Each task drives one scenario and compares against hand-computed values.
module tb_sram_port_ctrl;

   localparam int BITS = 32;
   localparam int WORDS = 36;
   localparam int AW = 6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            busy;
   logic            sram_cen;
   logic            sram_wen;
   logic [AW-1:0]   sram_adress;
   logic [BITS-1:0] sram_din;
   logic [BITS-1:0] sram_mask;
   logic [BITS-1:0] sram_dout;

   int checks = 0;
   int errors = 0;
   int cen_count = 0;

   logic [BITS-1:0] mem [0:63];

   sram_port_ctrl_if #(.BITS(BITS), .ADRESS_WIDTH(AW)) bus ();

   sram_port_ctrl #(
      .BITS         (BITS),
      .WORDS        (WORDS),
      .ADRESS_WIDTH (AW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .busy        (busy),
      .sram_cen    (sram_cen),
      .sram_wen    (sram_wen),
      .sram_adress (sram_adress),
      .sram_din    (sram_din),
      .sram_mask   (sram_mask),
      .sram_dout   (sram_dout)
   );

   always #5 clk = ~clk;

   assign sram_dout = (sram_cen && !sram_wen) ? mem[sram_adress] : '0;

   always @(posedge clk) begin
      if (sram_cen && sram_wen)
         mem[sram_adress] <= (mem[sram_adress] & sram_mask) |
                             (sram_din & ~sram_mask);
   end

   always @(posedge clk) begin
      if (sram_cen)
         cen_count <= cen_count + 1;
   end

   task automatic wr_burst(input logic [AW-1:0] a, input logic [2:0] l,
                           input logic [BITS-1:0] m,
                           input logic [BITS-1:0] d0);
      int n;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_adress = a;
      bus.req_len    = l;
      bus.req_mask   = m;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      for (int i = 0; i <= int'(l); i++) begin
         bus.wdata_valid = 1'b1;
         bus.wdata       = d0 + BITS'(i);
         n = 0;
         @(negedge clk);
         while (!bus.wdata_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (n >= 20) begin
            errors++;
            $display("FAIL wdata_ready_timeout beat %0d got 0 exp 1", i);
         end
         @(posedge clk);
         #1;
      end
      bus.wdata_valid = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_busy got %b%b exp 10",
                  bus.req_ready, busy);
      end
      checks++;
      if (bus.rdata_valid !== 1'b0 || bus.rdata !== '0 ||
          bus.rdata_last !== 1'b0 || bus.rdata_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_rdata got v%b d%h l%b e%b exp all 0",
                  bus.rdata_valid, bus.rdata, bus.rdata_last,
                  bus.rdata_err);
      end
      checks++;
      if (sram_cen !== 1'b0 || sram_wen !== 1'b0 ||
          sram_adress !== '0 || sram_din !== '0 || sram_mask !== '0) begin
         errors++;
         $display("FAIL reset_sram got cen%b wen%b a%h exp zeros",
                  sram_cen, sram_wen, sram_adress);
      end
   endtask

   task automatic test_write_burst;
      int c0;
      c0 = cen_count;
      wr_burst(6'd2, 3'd3, '0, 32'hA0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[2+i] !== 32'hA0 + i) begin
            errors++;
            $display("FAIL write_word%0d got %h exp %h",
                     2 + i, mem[2+i], 32'hA0 + i);
         end
      end
      checks++;
      if (cen_count - c0 !== 4) begin
         errors++;
         $display("FAIL write_cen_pulses got %0d exp 4", cen_count - c0);
      end
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL write_idle got %b%b exp 10", bus.req_ready, busy);
      end
   endtask

   task automatic test_read_burst;
      bus.rdata_ready = 1'b1;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_adress = 6'd2;
      bus.req_len    = 3'd3;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'hA0 + i ||
             bus.rdata_last !== (i == 3) || bus.rdata_err !== 1'b0) begin
            errors++;
            $display("FAIL read_beat%0d got v%b d%h l%b e%b exp 1 %h %b 0",
                     i, bus.rdata_valid, bus.rdata, bus.rdata_last,
                     bus.rdata_err, 32'hA0 + i, i == 3);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.rdata_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL read_drain got v%b b%b exp 00",
                  bus.rdata_valid, busy);
      end
   endtask

   task automatic test_wrap;
      int c0;
      c0 = cen_count;
      wr_burst(6'd34, 3'd2, '0, 32'hB0);
      checks++;
      if (mem[34] !== 32'hB0 || mem[35] !== 32'hB1 || mem[0] !== 32'hB2) begin
         errors++;
         $display("FAIL wrap_words got %h %h %h exp b0 b1 b2",
                  mem[34], mem[35], mem[0]);
      end
      checks++;
      if (cen_count - c0 !== 3) begin
         errors++;
         $display("FAIL wrap_cen_pulses got %0d exp 3", cen_count - c0);
      end
   endtask

   task automatic test_mask;
      wr_burst(6'd7, 3'd0, '0, 32'hDEADBEEF);
      wr_burst(6'd7, 3'd0, 32'hFFFF0000, 32'h12345678);
      checks++;
      if (mem[7] !== 32'hDEAD5678) begin
         errors++;
         $display("FAIL mask_word got %h exp dead5678", mem[7]);
      end
   endtask

   task automatic test_out_of_range;
      int c0;
      c0 = cen_count;
      bus.rdata_ready = 1'b1;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_adress = 6'd40;
      bus.req_len    = 3'd0;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.rdata_valid !== 1'b1 || bus.rdata !== '0 ||
          bus.rdata_err !== 1'b1 || bus.rdata_last !== 1'b1) begin
         errors++;
         $display("FAIL oor_read got v%b d%h e%b l%b exp 1 0 1 1",
                  bus.rdata_valid, bus.rdata, bus.rdata_err,
                  bus.rdata_last);
      end
      checks++;
      if (cen_count - c0 !== 0) begin
         errors++;
         $display("FAIL oor_cen got %0d exp 0", cen_count - c0);
      end
      @(negedge clk);
   endtask

   task automatic test_stall_reset;
      bus.rdata_ready = 1'b0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_adress = 6'd2;
      bus.req_len    = 3'd3;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'hA0) begin
         errors++;
         $display("FAIL stall_first got v%b d%h exp 1 a0",
                  bus.rdata_valid, bus.rdata);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'hA0 ||
             bus.rdata_last !== 1'b0 || sram_cen !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d got v%b d%h l%b cen%b exp 1 a0 0 0",
                     i, bus.rdata_valid, bus.rdata, bus.rdata_last,
                     sram_cen);
         end
      end
      bus.rdata_ready = 1'b1;
      #1;
      checks++;
      if (sram_cen !== 1'b1) begin
         errors++;
         $display("FAIL stall_release_cen got %b exp 1", sram_cen);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_adress !== '0 ||
          bus.rdata_valid !== 1'b0 || bus.rdata !== '0 ||
          bus.rdata_last !== 1'b0 || bus.rdata_err !== 1'b0 ||
          busy !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset got cen%b v%b d%h b%b r%b exp 0 0 0 0 1",
                  sram_cen, bus.rdata_valid, bus.rdata, busy,
                  bus.req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[2+i] !== 32'hA0 + i) begin
            errors++;
            $display("FAIL post_reset_word%0d got %h exp %h",
                     2 + i, mem[2+i], 32'hA0 + i);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle got %b%b exp 10",
                  bus.req_ready, busy);
      end
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.req_valid   = 1'b0;
      bus.req_write   = 1'b0;
      bus.req_adress  = '0;
      bus.req_len     = '0;
      bus.req_mask    = '0;
      bus.wdata_valid = 1'b0;
      bus.wdata       = '0;
      bus.rdata_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_write_burst();
      test_read_burst();
      test_wrap();
      test_mask();
      test_out_of_range();
      test_stall_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
